// File: rtl/rgmii_rx_pkg.sv
// rtl/rgmii_rx_pkg.sv - shared types and constants for the RGMII receive controller
package rgmii_rx_pkg;

    typedef enum logic [2:0] {
        INIT,
        FLUSH,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef logic [1:0] link_speed_t;

    localparam link_speed_t SPEED_10M  = 2'b00;
    localparam link_speed_t SPEED_100M = 2'b01;
    localparam link_speed_t SPEED_1G   = 2'b10;

endpackage

// File: rtl/rgmii_rx_inband_status.sv
// rtl/rgmii_rx_inband_status.sv - in-band link status capture during the inter-frame gap
module rgmii_rx_inband_status
    import rgmii_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        idle,
    input  logic        dv,
    input  logic        er,
    input  logic        stable,
    input  logic [3:0]  status_nib,
    output logic        link_up,
    output link_speed_t link_speed,
    output logic        link_duplex
);

    logic        link_up_q, link_up_d;
    link_speed_t speed_q, speed_d;
    logic        duplex_q, duplex_d;

    // Status is only trusted when both DDR halves carry the same nibble.
    always_comb begin
        link_up_d = link_up_q;
        speed_d   = speed_q;
        duplex_d  = duplex_q;
        if (idle && !dv && !er && stable) begin
            link_up_d = status_nib[0];
            speed_d   = status_nib[2:1];
            duplex_d  = status_nib[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_up_q <= 1'b0;
            speed_q   <= SPEED_10M;
            duplex_q  <= 1'b0;
        end else begin
            link_up_q <= link_up_d;
            speed_q   <= speed_d;
            duplex_q  <= duplex_d;
        end
    end

    assign link_up     = link_up_q;
    assign link_speed  = speed_q;
    assign link_duplex = duplex_q;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// rtl/rgmii_rx_ctrl.sv - RGMII receive IDDR sequencing, byte assembly and framing
module rgmii_rx_ctrl
    import rgmii_rx_pkg::*;
#(
    parameter int IDDR_RST_CYCLES = 16,
    parameter int PREAMBLE_MAX    = 7,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             iddr_rst,
    output logic             iddr_ce,
    input  logic [3:0]       rxd_q1,
    input  logic [3:0]       rxd_q2,
    input  logic             ctl_q1,
    input  logic             ctl_q2,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_error,
    output logic             link_up,
    output link_speed_t      link_speed,
    output logic             link_duplex,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int TMR_W  = $clog2(IDDR_RST_CYCLES + 1);
    localparam int PRE_W  = $clog2(PREAMBLE_MAX + 2);
    localparam int BYTE_W = $clog2(MAX_FRAME_BYTES + 1);

    logic [7:0]       s1_byte_q, s1_byte_d;
    logic             s1_dv_q, s1_dv_d, s1_er_q, s1_er_d, s1_eq_q, s1_eq_d;
    rx_state_t        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             iddr_rst_q, iddr_rst_d, iddr_ce_q, iddr_ce_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d, sticky_q, sticky_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d, m_last_q, m_last_d, m_error_q, m_error_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             frame_inc, drop_inc;

    always_comb begin
        s1_byte_d = {rxd_q2, rxd_q1};
        s1_dv_d   = ctl_q1;
        s1_er_d   = ctl_q1 ^ ctl_q2;
        s1_eq_d   = (rxd_q1 == rxd_q2);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        iddr_rst_d   = iddr_rst_q;
        iddr_ce_d    = iddr_ce_q;
        pre_cnt_d    = pre_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sticky_d     = sticky_q;
        m_data_d     = m_data_q;
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        m_error_d    = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;
        case (state_q)
            INIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TMR_W'(IDDR_RST_CYCLES)) begin
                    iddr_rst_d = 1'b0;
                    iddr_ce_d  = 1'b1;
                    timer_d    = '0;
                    state_d    = FLUSH;
                end
            end
            // Two IDDR pipeline stages plus our own decode register.
            FLUSH: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TMR_W'(2)) state_d = IDLE;
            end
            IDLE: begin
                if (s1_dv_q) begin
                    if (s1_er_q) begin
                        state_d  = DROP;
                        drop_inc = 1'b1;
                    end else if (s1_byte_q == PREAMBLE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end else if (s1_byte_q == SFD_BYTE) begin
                        state_d = DATA;
                    end else begin
                        state_d  = DROP;
                        drop_inc = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!s1_dv_q) begin
                    state_d = IDLE;
                end else if (!s1_er_q && s1_byte_q == PREAMBLE_BYTE) begin
                    if (pre_cnt_q == PRE_W'(PREAMBLE_MAX)) begin
                        state_d  = DROP;
                        drop_inc = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end else if (!s1_er_q && s1_byte_q == SFD_BYTE) begin
                    state_d = DATA;
                end else begin
                    state_d  = DROP;
                    drop_inc = 1'b1;
                end
            end
            // One byte is always held back so the end of frame can tag it with m_last.
            DATA: begin
                if (s1_dv_q && byte_cnt_q == BYTE_W'(MAX_FRAME_BYTES)) begin
                    m_data_d  = hold_q;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_error_d = 1'b1;
                    drop_inc  = 1'b1;
                    state_d   = DROP;
                end else if (s1_dv_q) begin
                    if (hold_valid_q) begin
                        m_data_d  = hold_q;
                        m_valid_d = 1'b1;
                    end
                    hold_d       = s1_byte_q;
                    hold_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 1'b1;
                    if (s1_er_q) sticky_d = 1'b1;
                end else begin
                    if (hold_valid_q) begin
                        m_data_d  = hold_q;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_error_d = sticky_q;
                        frame_inc = !sticky_q;
                        drop_inc  = sticky_q;
                    end else begin
                        drop_inc = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!s1_dv_q) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
        if (state_d == DATA && state_q != DATA) begin
            byte_cnt_d   = '0;
            hold_valid_d = 1'b0;
            sticky_d     = 1'b0;
        end
        frame_cnt_d = (frame_inc && frame_cnt_q != '1) ? frame_cnt_q + 1'b1 : frame_cnt_q;
        drop_cnt_d  = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_byte_q    <= '0;
            s1_dv_q      <= 1'b0;
            s1_er_q      <= 1'b0;
            s1_eq_q      <= 1'b0;
            state_q      <= INIT;
            timer_q      <= '0;
            iddr_rst_q   <= 1'b1;
            iddr_ce_q    <= 1'b0;
            pre_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_error_q    <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            s1_byte_q    <= s1_byte_d;
            s1_dv_q      <= s1_dv_d;
            s1_er_q      <= s1_er_d;
            s1_eq_q      <= s1_eq_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            iddr_rst_q   <= iddr_rst_d;
            iddr_ce_q    <= iddr_ce_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sticky_q     <= sticky_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_error_q    <= m_error_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    rgmii_rx_inband_status u_inband (
        .clk         (clk),
        .rst         (rst),
        .idle        (state_q == IDLE),
        .dv          (s1_dv_q),
        .er          (s1_er_q),
        .stable      (s1_eq_q),
        .status_nib  (s1_byte_q[3:0]),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .link_duplex (link_duplex)
    );

    assign iddr_rst  = iddr_rst_q;
    assign iddr_ce   = iddr_ce_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_error   = m_error_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// tb/tb_rgmii_rx_ctrl.sv - directed self-checking bench for rgmii_rx_ctrl
module tb_rgmii_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iddr_rst, iddr_ce;
    logic [3:0]  rxd_q1, rxd_q2;
    logic        ctl_q1, ctl_q2;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_error;
    logic        link_up, link_duplex;
    logic [1:0]  link_speed;
    logic [15:0] frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    rgmii_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .iddr_rst    (iddr_rst),
        .iddr_ce     (iddr_ce),
        .rxd_q1      (rxd_q1),
        .rxd_q2      (rxd_q2),
        .ctl_q1      (ctl_q1),
        .ctl_q2      (ctl_q2),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_error     (m_error),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .link_duplex (link_duplex),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       err;
        int         cyc;
    } beat_t;

    beat_t beats[$];
    int    cyc = 0;
    int    bad_idle_flags = 0;
    int    checks = 0;
    int    errors = 0;
    int    first_edge, last_edge;
    int    rst_hi, ce_first;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid) beats.push_back('{m_data, m_last, m_error, cyc});
        else if (m_last || m_error) bad_idle_flags++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] b);
        rxd_q1 = b[3:0];
        rxd_q2 = b[7:4];
        ctl_q1 = dv;
        ctl_q2 = dv ^ er;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int npre, input int ndata, input int er_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < ndata; i++) begin
            drive(1'b1, i == er_idx, 8'(i));
            if (i == 0) first_edge = cyc;
            last_edge = cyc;
        end
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    function automatic int data_errs();
        int n = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i].d !== 8'(i)) n++;
        return n;
    endfunction

    function automatic int last_count();
        int n = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i].last) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b1;
        rxd_q1 = 4'h0;
        rxd_q2 = 4'h0;
        ctl_q1 = 1'b0;
        ctl_q2 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_iddr_rst", iddr_rst, 1);
        check_eq("rst_iddr_ce", iddr_ce, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_link_up", link_up, 0);
        check_eq("rst_link_speed", link_speed, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);

        rst = 1'b0;
        rst_hi = 0;
        ce_first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (iddr_rst) rst_hi++;
            if (iddr_ce && ce_first == 0) ce_first = k;
        end
        check_eq("init_rst_cycles", rst_hi, 16);
        check_eq("init_ce_first", ce_first, 17);
        check_eq("init_no_valid", beats.size(), 0);

        beats.delete();
        send_frame(7, 64, -1);
        check_eq("f64_beats", beats.size(), 64);
        check_eq("f64_data", data_errs(), 0);
        check_eq("f64_last_cnt", last_count(), 1);
        check_eq("f64_last_pos", beats[63].last, 1);
        check_eq("f64_error", beats[63].err, 0);
        check_eq("f64_first_lat", beats[0].cyc - first_edge, 2);
        check_eq("f64_last_lat", beats[63].cyc - last_edge, 2);
        check_eq("f64_frame_cnt", frame_cnt, 1);
        check_eq("f64_drop_cnt", drop_cnt, 0);

        beats.delete();
        send_frame(7, 64, 10);
        check_eq("er_beats", beats.size(), 64);
        check_eq("er_data", data_errs(), 0);
        check_eq("er_last_pos", beats[63].last, 1);
        check_eq("er_error", beats[63].err, 1);
        check_eq("er_drop_cnt", drop_cnt, 1);
        check_eq("er_frame_cnt", frame_cnt, 1);

        beats.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hAA);
        drive(1'b0, 1'b0, 8'h00);
        check_eq("longpre_drop_cnt", drop_cnt, 2);
        check_eq("longpre_no_beats", beats.size(), 0);
        send_frame(7, 16, -1);
        check_eq("b2b_beats", beats.size(), 16);
        check_eq("b2b_data", data_errs(), 0);
        check_eq("b2b_last_pos", beats[15].last, 1);
        check_eq("b2b_frame_cnt", frame_cnt, 2);

        beats.delete();
        send_frame(7, 1523, -1);
        check_eq("over_beats", beats.size(), 1522);
        check_eq("over_data", data_errs(), 0);
        check_eq("over_last_cnt", last_count(), 1);
        check_eq("over_last_pos", beats[1521].last, 1);
        check_eq("over_error", beats[1521].err, 1);
        check_eq("over_drop_cnt", drop_cnt, 3);
        check_eq("over_frame_cnt", frame_cnt, 2);

        beats.delete();
        send_frame(7, 1522, -1);
        check_eq("max_beats", beats.size(), 1522);
        check_eq("max_last_pos", beats[1521].last, 1);
        check_eq("max_error", beats[1521].err, 0);
        check_eq("max_frame_cnt", frame_cnt, 3);

        repeat (3) drive(1'b0, 1'b0, 8'hDD);
        check_eq("link_up", link_up, 1);
        check_eq("link_speed", link_speed, 2'b10);
        check_eq("link_duplex", link_duplex, 1);

        beats.delete();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hA0 + 8'(i));
        check_eq("mid_valid_pre", m_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", m_valid, 0);
        check_eq("mid_rst_last", m_last, 0);
        check_eq("mid_rst_link_up", link_up, 0);
        check_eq("mid_rst_speed", link_speed, 0);
        check_eq("mid_rst_frame_cnt", frame_cnt, 0);
        check_eq("mid_rst_drop_cnt", drop_cnt, 0);
        check_eq("mid_rst_iddr_rst", iddr_rst, 1);
        check_eq("mid_rst_iddr_ce", iddr_ce, 0);
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check_eq("mid_rst_no_last", last_count(), 0);
        check_eq("idle_flags_clear", bad_idle_flags, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
